// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and helpers for the systolic array sequencing controller.
//   seq_state_t   controller state encoding (IDLE -> CLEAR -> FEED -> DRAIN -> DONE)
//   CTR_W         width of the shared FEED/DRAIN phase counter (K and 2N-1 must fit)
//   DRAIN_CYCLES  cycles the wavefront needs to leave an N x N array after the last beat
package systolic_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFeed,
      StDrain,
      StDone
   } seq_state_t;

   // One counter serves both FEED (0..K-1) and DRAIN (0..2N-2).
   localparam int unsigned CTR_W = 8;

   function automatic int unsigned DRAIN_CYCLES(input int unsigned n);
      return 2 * n - 1;
   endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: job handshake, operand-buffer read bus and array edge feed of the
// systolic sequencing controller.
//   start/busy/done       job request and status
//   rd_en/rd_addr         operand buffer read (1-cycle latency), a_col/b_row read data
//   arr_a/arr_b/pe_clear  left/top edge feed and PE clear
//   abort                 only when SYSTOLIC_CTRL_ABORT_EN is defined
// Modports: master = controller, slave = operand buffer / array / job source.
interface systolic_seq_ctrl_if #(
   parameter int unsigned N         = 4,
   parameter int unsigned K         = 4,
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned AW        = (K > 1) ? $clog2(K) : 1
);
   logic                   start;
   logic                   busy;
   logic                   done;
   logic                   rd_en;
   logic [AW-1:0]          rd_addr;
   logic [N*DATA_SIZE-1:0] a_col;
   logic [N*DATA_SIZE-1:0] b_row;
   logic [N*DATA_SIZE-1:0] arr_a;
   logic [N*DATA_SIZE-1:0] arr_b;
   logic                   pe_clear;
`ifdef SYSTOLIC_CTRL_ABORT_EN
   logic                   abort;

   modport master (
      input  start, a_col, b_row, abort,
      output busy, done, rd_en, rd_addr, arr_a, arr_b, pe_clear
   );
   modport slave (
      output start, a_col, b_row, abort,
      input  busy, done, rd_en, rd_addr, arr_a, arr_b, pe_clear
   );
`else
   modport master (
      input  start, a_col, b_row,
      output busy, done, rd_en, rd_addr, arr_a, arr_b, pe_clear
   );
   modport slave (
      output start, a_col, b_row,
      input  busy, done, rd_en, rd_addr, arr_a, arr_b, pe_clear
   );
`endif
endinterface

// File: rtl/skew_delay.sv
// skew_delay: WIDTH-bit delay line of DEPTH cycles with synchronous clear.
//   clk, reset  clock and synchronous active-high clear of every stage
//   din/dout    lane input / lane output delayed DEPTH cycles (DEPTH=0: plain wire)
module skew_delay #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign dout = din;
   end else begin : g_shift
      logic [WIDTH-1:0] sr_q [DEPTH];

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) sr_q[i] <= '0;
         end else begin
            sr_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) sr_q[i] <= sr_q[i-1];
         end
      end

      assign dout = sr_q[DEPTH-1];
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequencing controller for an N x N systolic multiply array.
// Reads one A column / B row per FEED cycle, skews lane i by i cycles, feeds zero outside
// the operand window, clears the PEs, waits 2N-1 drain cycles and pulses done.
//   clk    single clock, posedge
//   reset  synchronous active-high reset
//   bus    systolic_seq_ctrl_if master modport (handshake, operand read, edge feed)
// Optional: define SYSTOLIC_CTRL_ABORT_EN to add bus.abort (cancel a running job).
// Constraint: K and 2N-1 must each fit in CTR_W bits.
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int unsigned N         = 4,
   parameter int unsigned K         = 4,
   parameter int unsigned DATA_SIZE = 8
) (
   input logic                 clk,
   input logic                 reset,
   systolic_seq_ctrl_if.master bus
);

   localparam int unsigned AW = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned W  = N * DATA_SIZE;

   seq_state_t       state_q, state_d;
   logic [CTR_W-1:0] cnt_q, cnt_d;
   logic             vld_q;    // rd_en delayed one cycle: read data is on a_col/b_row
   logic             flush_q;  // abort accepted last cycle: hold pe_clear for one cycle
   logic             abort_hit;
   logic             skew_clr;
   logic             feed;

`ifdef SYSTOLIC_CTRL_ABORT_EN
   assign abort_hit = bus.abort && (state_q inside {StClear, StFeed, StDrain});
`else
   assign abort_hit = 1'b0;
`endif

   assign feed     = (state_q == StFeed);
   assign skew_clr = reset | abort_hit;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vld_q   <= feed & ~abort_hit;
         flush_q <= abort_hit;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StClear;
         StClear: begin
            state_d = StFeed;
            cnt_d   = '0;
         end
         StFeed: begin
            if (cnt_q == CTR_W'(K - 1)) begin
               state_d = StDrain;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDrain: begin
            if (cnt_q == CTR_W'(DRAIN_CYCLES(N) - 1)) begin
               state_d = StDone;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (abort_hit) begin
         state_d = StIdle;
         cnt_d   = '0;
      end
   end

   // Outputs; reset forces every status/feed output low immediately
   logic          busy_o, done_o, rd_en_o, pe_clear_o;
   logic [AW-1:0] rd_addr_o;

   always_comb begin
      busy_o     = ~reset & (state_q inside {StClear, StFeed, StDrain});
      done_o     = ~reset & (state_q == StDone);
      rd_en_o    = ~reset & feed;
      rd_addr_o  = rd_en_o ? cnt_q[AW-1:0] : '0;
      pe_clear_o = reset | (state_q == StClear) | flush_q;
   end

   // Per-lane capture gating and diagonal skew
   logic [W-1:0] a_skew, b_skew;

   for (genvar g = 0; g < int'(N); g++) begin : g_lane
      logic [DATA_SIZE-1:0] a_cap, b_cap;

      assign a_cap = vld_q ? bus.a_col[g*DATA_SIZE +: DATA_SIZE] : '0;
      assign b_cap = vld_q ? bus.b_row[g*DATA_SIZE +: DATA_SIZE] : '0;

      skew_delay #(.DEPTH(g), .WIDTH(DATA_SIZE)) u_skew_a (
         .clk   (clk),
         .reset (skew_clr),
         .din   (a_cap),
         .dout  (a_skew[g*DATA_SIZE +: DATA_SIZE])
      );

      skew_delay #(.DEPTH(g), .WIDTH(DATA_SIZE)) u_skew_b (
         .clk   (clk),
         .reset (skew_clr),
         .din   (b_cap),
         .dout  (b_skew[g*DATA_SIZE +: DATA_SIZE])
      );
   end

   assign bus.busy     = busy_o;
   assign bus.done     = done_o;
   assign bus.rd_en    = rd_en_o;
   assign bus.rd_addr  = rd_addr_o;
   assign bus.pe_clear = pe_clear_o;
   assign bus.arr_a    = reset ? '0 : a_skew;
   assign bus.arr_b    = reset ? '0 : b_skew;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl (N=K=4, DATA_SIZE=8): operand buffer model, behavioural
// 4x4 PE array on the edge feed, table of jobs with per-cycle timeline checks and a
// scoreboard of expected C matrices popped at every done pulse.
module tb_systolic_seq_ctrl;

   localparam int unsigned N   = 4;
   localparam int unsigned K   = 4;
   localparam int unsigned DS  = 8;
   localparam int unsigned CW  = 2 * DS + 1;
   localparam int          LAT = K + 2 * N + 1;  // start cycle -> done cycle

   typedef logic [3:0][3:0][7:0]    mat8_t;
   typedef logic [3:0][3:0][CW-1:0] matc_t;

   typedef struct {
      mat8_t         a;
      mat8_t         b;
      bit            has_corner;
      logic [CW-1:0] exp_corner;
   } job_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   systolic_seq_ctrl_if #(.N(N), .K(K), .DATA_SIZE(DS)) bus ();

   systolic_seq_ctrl #(.N(N), .K(K), .DATA_SIZE(DS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   job_t  jobs [4];
   matc_t exp_q [$];
   mat8_t cur_a, cur_b;
   int    total = 0;
   int    bad   = 0;

   task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic matc_t matmul(input mat8_t a, input mat8_t b);
      matc_t c = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++)
               c[i][j] = c[i][j] + CW'(a[i][k]) * CW'(b[k][j]);
      return c;
   endfunction

   // Operand buffer: one-cycle read latency
   always @(posedge clk) begin
      if (bus.rd_en) begin
         for (int i = 0; i < 4; i++) begin
            bus.a_col[i*DS +: DS] <= cur_a[i][bus.rd_addr];
            bus.b_row[i*DS +: DS] <= cur_b[bus.rd_addr][i];
         end
      end
   end

   // Behavioural PE array: accumulate every cycle, pass a right and b down
   matc_t acc;
   mat8_t ar, br;
   always @(posedge clk) begin
      logic [7:0] ia, ib;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (j == 0) ia = bus.arr_a[i*DS +: DS];
            else        ia = ar[i][j-1];
            if (i == 0) ib = bus.arr_b[j*DS +: DS];
            else        ib = br[i-1][j];
            if (bus.pe_clear) begin
               acc[i][j] <= '0;
               ar[i][j]  <= '0;
               br[i][j]  <= '0;
            end else begin
               acc[i][j] <= acc[i][j] + CW'(ia) * CW'(ib);
               ar[i][j]  <= ia;
               br[i][j]  <= ib;
            end
         end
      end
   end

   // Scoreboard: every done pulse must match the oldest outstanding job
   always @(negedge clk) begin
      if (bus.done) begin
         check("done_has_job", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) check("c_matrix", acc, exp_q.pop_front());
      end
   end

   // Drive one job from IDLE and check the full cycle-by-cycle timeline
   task automatic run_job(input int idx);
      logic [N*DS-1:0] ea, eb;
      cur_a = jobs[idx].a;
      cur_b = jobs[idx].b;
      exp_q.push_back(matmul(cur_a, cur_b));
      bus.start = 1'b1;
      @(posedge clk);
      for (int t = 1; t <= LAT + 1; t++) begin
         @(negedge clk);
         if (t == 1) bus.start = 1'b0;
         check($sformatf("j%0d busy@%0d", idx, t), bus.busy, (t >= 1 && t <= LAT - 1));
         check($sformatf("j%0d done@%0d", idx, t), bus.done, (t == LAT));
         check($sformatf("j%0d pe_clear@%0d", idx, t), bus.pe_clear, (t == 1));
         check($sformatf("j%0d rd_en@%0d", idx, t), bus.rd_en, (t >= 2 && t <= K + 1));
         if (t >= 2 && t <= K + 1)
            check($sformatf("j%0d rd_addr@%0d", idx, t), bus.rd_addr, t - 2);
         for (int i = 0; i < 4; i++) begin
            int kk = t - 3 - i;
            ea[i*DS +: DS] = (kk >= 0 && kk < int'(K)) ? cur_a[i][kk] : 8'h00;
            eb[i*DS +: DS] = (kk >= 0 && kk < int'(K)) ? cur_b[kk][i] : 8'h00;
         end
         check($sformatf("j%0d arr_a@%0d", idx, t), bus.arr_a, ea);
         check($sformatf("j%0d arr_b@%0d", idx, t), bus.arr_b, eb);
         if (t == LAT && jobs[idx].has_corner)
            check($sformatf("j%0d c33", idx), acc[3][3], jobs[idx].exp_corner);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"}, bus.busy, 1'b0);
      check({tag, " done"}, bus.done, 1'b0);
      check({tag, " rd_en"}, bus.rd_en, 1'b0);
      check({tag, " rd_addr"}, bus.rd_addr, 0);
      check({tag, " arr_a"}, bus.arr_a, 0);
      check({tag, " arr_b"}, bus.arr_b, 0);
      check({tag, " pe_clear"}, bus.pe_clear, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d1, d2, cyc;

      // Job table
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            jobs[0].a[i][j] = (i == j) ? 8'd1 : 8'd0;
            jobs[0].b[i][j] = 8'(i * 4 + j + 1);
            jobs[1].a[i][j] = 8'hFF;
            jobs[1].b[i][j] = 8'hFF;
            jobs[2].a[i][j] = 8'h11;
            jobs[2].b[i][j] = (i == j) ? 8'd1 : 8'd0;
            jobs[3].a[i][j] = 8'($urandom_range(0, 255));
            jobs[3].b[i][j] = 8'($urandom_range(0, 255));
         end
      end
      jobs[0].has_corner = 1'b1; jobs[0].exp_corner = 17'd16;
      jobs[1].has_corner = 1'b1; jobs[1].exp_corner = 17'h3F804;
      jobs[2].has_corner = 1'b1; jobs[2].exp_corner = 17'h11;
      jobs[3].has_corner = 1'b0; jobs[3].exp_corner = '0;

      reset     = 1'b1;
      bus.start = 1'b0;
`ifdef SYSTOLIC_CTRL_ABORT_EN
      bus.abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b0;
      @(negedge clk);
      check("idle pe_clear", bus.pe_clear, 1'b0);
      check("idle busy", bus.busy, 1'b0);

      for (int j = 0; j < 4; j++) run_job(j);

      // start held high: jobs accepted only from IDLE, fixed done spacing
      cur_a = jobs[0].a;
      cur_b = jobs[0].b;
      exp_q.push_back(matmul(cur_a, cur_b));
      exp_q.push_back(matmul(cur_a, cur_b));
      d1 = -1; d2 = -1; cyc = 0;
      bus.start = 1'b1;
      while (cyc < 60 && d2 < 0) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            if (d1 < 0) d1 = cyc;
            else begin
               d2 = cyc;
               bus.start = 1'b0;
            end
         end
      end
      bus.start = 1'b0;
      check("held first_done", d1, LAT);
      check("held done_spacing", d2 - d1, LAT + 1);
      repeat (2) @(negedge clk);
      check("held idle_after", bus.busy, 1'b0);

      // Reset mid-FEED for 3 cycles: outputs forced, no done afterwards
      cur_a = jobs[1].a;
      cur_b = jobs[1].b;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      check("midfeed rd_en", bus.rd_en, 1'b1);
      reset = 1'b1;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         check_reset_outputs($sformatf("rst%0d", r));
      end
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check($sformatf("postrst busy@%0d", c), bus.busy, 1'b0);
         check($sformatf("postrst done@%0d", c), bus.done, 1'b0);
      end

`ifdef SYSTOLIC_CTRL_ABORT_EN
      // Abort during FEED at s+4, restart at s+6
      cur_a = jobs[1].a;
      cur_b = jobs[1].b;
      bus.start = 1'b1;
      @(posedge clk);
      for (int t = 1; t <= 4; t++) begin
         @(negedge clk);
         if (t == 1) bus.start = 1'b0;
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort busy", bus.busy, 1'b0);
      check("abort pe_clear", bus.pe_clear, 1'b1);
      check("abort rd_en", bus.rd_en, 1'b0);
      check("abort arr_a", bus.arr_a, 0);
      check("abort arr_b", bus.arr_b, 0);
      @(negedge clk);
      check("abort pe_clear_off", bus.pe_clear, 1'b0);
      run_job(2);
`endif

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencing controller for the N×N systolic multiply array built from `pe_generic` processing elements. It fetches one column of A and one row of B per cycle from external operand buffers, applies the diagonal skew, and feeds zeros at the array edges outside the operand window. It drives the PE clear line, waits for the wavefront to drain, and pulses `done` once every PE accumulator holds its final C element.

## Interface
Parameters:
- `N`, 4: array dimension (rows = cols); N ≥ 2.
- `K`, 4: inner dimension (operand beats per job); K ≥ 1.
- `DATA_SIZE`, 8: operand width, matching the PE `data_size`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `busy`  out  1  high in CLEAR, FEED and DRAIN.
- `done`  out  1  one-cycle pulse; array results are final.
- `rd_en`  out  1  operand buffer read strobe; read latency is exactly 1 cycle.
- `rd_addr`  out  $clog2(K)  beat index k.
- `a_col`  in  N*DATA_SIZE  lane i = A[i][k], valid the cycle after `rd_en`.
- `b_row`  in  N*DATA_SIZE  lane j = B[k][j], valid the cycle after `rd_en`.
- `arr_a`  out  N*DATA_SIZE  left-edge feed; lane i drives row i `in_a`.
- `arr_b`  out  N*DATA_SIZE  top-edge feed; lane j drives column j `in_b`.
- `pe_clear`  out  1  drives the `reset` input of every PE.
- `abort`  in  1  present only with `SYSTOLIC_CTRL_ABORT_EN`.

## Operation
- States: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE: `start`=1 → CLEAR. `start` is ignored in every other state. No queueing.
- CLEAR: 1 cycle. `pe_clear`=1, which zeroes the accumulators and the a/b pass registers.
- FEED: K cycles. `rd_en`=1, `rd_addr`=0..K-1 in order. Counter wraps to 0 on exit.
- DRAIN: 2N-1 cycles. `rd_en`=0.
- DONE: 1 cycle. `done`=1, then IDLE.
- `pe_clear` = `reset` OR (state==CLEAR).
- Capture valid: a registered flag equal to `rd_en` delayed 1 cycle. When the flag is high, the `a_col`/`b_row` lanes enter the skew lines. When the flag is low, zero enters.
- Skew: lane i of `arr_a` is the captured lane i delayed i cycles; lane 0 has no added delay. `arr_b` uses the same rule per column lane.
- Zero fill is mandatory. The PE accumulates every cycle, so any non-zero edge value outside the window corrupts C.
- After DONE, the skew lines hold zero. C stays stable in IDLE until the next CLEAR.
- Reset, at any time: state=IDLE, skew registers=0, capture flag=0, counters=0.
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `arr_a`=0, `arr_b`=0, `pe_clear`=1 while `reset` is high.
- Width rule: the controller passes operands unmodified. C width (2*DATA_SIZE+1) is owned by the PE. The K·max² overflow budget is the integrator's responsibility.

## Timing
- Cycle s: `start` sampled in IDLE. Cycle s+1: CLEAR. Cycle s+2: first FEED beat (k=0).
- Beat k is read at s+2+k. It appears on `arr_a` lane i at s+3+k+i.
- PE(i,j) accumulates A[i][k]·B[k][j] during cycle s+3+k+i+j.
- Last accumulation is at s+K+2N. `done`=1 at s+K+2N+1; `busy` falls the same cycle.
- Earliest next `start` is accepted at s+K+2N+2 (IDLE).

## Configuration
- `SYSTOLIC_CTRL_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 in CLEAR, FEED or DRAIN → next cycle IDLE with `pe_clear`=1 for that one cycle. Skew lines and capture flag are zeroed. No `done`.
  - `abort` is ignored in IDLE and DONE.
- Not defined: no `abort` port. A job always runs to `done`.

## Structure
- Shared package `systolic_pkg`:
  - state enum `seq_state_t`
  - `DRAIN_CYCLES(N)=2*N-1` function
  - localparam for counter width
- Sub-module `skew_delay`:
  - parameters DEPTH and WIDTH
  - synchronous-reset shift register
  - DEPTH=0 means a wire
  - instantiated once per lane for A and once per lane for B

## Test plan
- Reset: hold `reset` for 3 cycles mid-FEED → all outputs 0, `pe_clear`=1 throughout, state IDLE after release; no `done` follows.
- Sequencing (N=4, K=4): `start` at cycle s → CLEAR at s+1; `rd_addr` 0,1,2,3 at s+2..s+5; `done` pulse only at s+13; `busy` high s+1..s+12.
- Skew/zero fill: `a_col`=all lanes 0x11 every read beat → `arr_a` lane 3 is 0 before s+6, 0x11 s+6..s+9, 0 after; lane 0 non-zero only s+3..s+6.
- End-to-end with a 4×4 `pe_generic` array: A=identity, B=1..16 row-major → at `done`, C=B. A=all 0xFF, B=all 0xFF, K=4 → every C=0x3F804.
- `start` held high continuously → jobs accepted only from IDLE; `done` spacing exactly K+2N+2=14 cycles.
- With `SYSTOLIC_CTRL_ABORT_EN`: `abort` at s+4 → IDLE at s+5, `pe_clear`=1 at s+5, no `done`. A new `start` at s+6 yields a correct result at s+19.
